// File: rtl/band_bar_renderer_if.sv
// Pixel-stream bundle between the bar renderer and its consumer: frame request
// inputs plus the plot stream and frame status outputs.
interface band_bar_renderer_if #(
  parameter int NUM_BANDS = 8,
  parameter int AMP_W     = 8,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
);
  logic                       start;
  logic [NUM_BANDS*AMP_W-1:0] amps;
  logic [2:0]                 bar_colour;
  logic [X_W-1:0]             x;
  logic [Y_W-1:0]             y;
  logic [2:0]                 colour;
  logic                       plot;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, amps, bar_colour,
    output x, y, colour, plot, busy, done
  );

  modport slave (
    output start, amps, bar_colour,
    input  x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/band_bar_renderer.sv
// Multi-band bar-graph renderer: scales each band amplitude to a bar height and
// streams every pixel of the bar region column-major. Optional macro PEAK_HOLD_EN.
module band_bar_renderer #(
  parameter int NUM_BANDS = 8,
  parameter int AMP_W     = 8,
  parameter int BAR_W     = 16,
  parameter int SCREEN_H  = 120,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
) (
  input  logic               clk,
  input  logic               reset,
  band_bar_renderer_if.master bus
);

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int PW = AMP_W + Y_W;
  localparam logic [BW-1:0] BAND_LAST = BW'(NUM_BANDS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(BAR_W - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [Y_W:0]   H_TOP    = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, SCALE, DRAW, DONE} state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              band_q, band_d;
  logic [CW-1:0]              col_q, col_d;
  logic [Y_W-1:0]             row_q, row_d;
  logic [Y_W-1:0]             height_q, height_d;
  logic [NUM_BANDS*AMP_W-1:0] amps_q, amps_d;
  logic [2:0]                 bar_colour_q, bar_colour_d;
  logic [X_W-1:0]             x_q, x_d;
  logic [Y_W-1:0]             y_q, y_d;
  logic [2:0]                 colour_q, colour_d;
  logic                       plot_q, plot_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [AMP_W-1:0] amp_sel;
  logic [PW-1:0]    amp_prod;
  logic [Y_W-1:0]   height_calc;
  logic [2:0]       pix_colour;

  assign amp_sel     = amps_q[band_q*AMP_W +: AMP_W];
  assign amp_prod    = PW'(amp_sel) * PW'(SCREEN_H);
  assign height_calc = amp_prod[AMP_W +: Y_W];

`ifdef PEAK_HOLD_EN
  logic [Y_W-1:0] peak_q [NUM_BANDS];
  logic [Y_W-1:0] peak_d [NUM_BANDS];

  // Peaks track the bar height of the frame being drawn and decay one row per frame.
  always_comb begin
    for (int i = 0; i < NUM_BANDS; i++) peak_d[i] = peak_q[i];
    if (state_q == SCALE) begin
      if (height_calc > peak_q[band_q]) peak_d[band_q] = height_calc;
      else if (peak_q[band_q] != '0)    peak_d[band_q] = peak_q[band_q] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (reset) peak_q[i] <= '0;
      else       peak_q[i] <= peak_d[i];
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    band_d       = band_q;
    col_d        = col_q;
    row_d        = row_q;
    height_d     = height_q;
    amps_d       = amps_q;
    bar_colour_d = bar_colour_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          amps_d       = bus.amps;
          bar_colour_d = bus.bar_colour;
          band_d       = '0;
          state_d      = SCALE;
        end
      end
      SCALE: begin
        height_d = height_calc;
        col_d    = '0;
        row_d    = '0;
        state_d  = DRAW;
      end
      DRAW: begin
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (col_q == COL_LAST) begin
            if (band_q == BAND_LAST) state_d = DONE;
            else begin
              band_d  = band_q + 1'b1;
              state_d = SCALE;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output registers are loaded from the next-state counters so the pixel
    // appears in the same cycle the FSM sits on it.
    pix_colour = ({1'b0, row_d} >= (H_TOP - {1'b0, height_d})) ? bar_colour_q : 3'b000;
`ifdef PEAK_HOLD_EN
    if (peak_d[band_d] != '0 && {1'b0, row_d} == (H_TOP - {1'b0, peak_d[band_d]}))
      pix_colour = 3'b111;
`endif
    plot_d   = (state_d == DRAW);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    x_d      = X_W'(int'(band_d) * BAR_W + int'(col_d));
    y_d      = row_d;
    colour_d = plot_d ? pix_colour : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      band_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      height_q     <= '0;
      amps_q       <= '0;
      bar_colour_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      band_q       <= band_d;
      col_q        <= col_d;
      row_q        <= row_d;
      height_q     <= height_d;
      amps_q       <= amps_d;
      bar_colour_q <= bar_colour_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_band_bar_renderer.sv
// Scoreboard bench for band_bar_renderer: expected pixels are queued when a frame
// is accepted and popped against every plotted pixel.
module tb_band_bar_renderer;

  localparam int NB  = 8;
  localparam int AW  = 8;
  localparam int BWP = 16;
  localparam int SH  = 120;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int DONE_CYC = NB * (1 + BWP * SH) + 1;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [XW+YW+2:0] exp_q [$];
  int   peak_m [NB];

  band_bar_renderer_if #(.NUM_BANDS(NB), .AMP_W(AW), .X_W(XW), .Y_W(YW)) tif ();

  band_bar_renderer #(
    .NUM_BANDS(NB), .AMP_W(AW), .BAR_W(BWP), .SCREEN_H(SH), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model of one frame, pushed in plot order.
  task automatic push_frame(input logic [NB*AW-1:0] a, input logic [2:0] c);
    for (int b = 0; b < NB; b++) begin
      int amp;
      int h;
      amp = int'(a[b*AW +: AW]);
      h   = (amp * SH) / 256;
`ifdef PEAK_HOLD_EN
      if (h > peak_m[b]) peak_m[b] = h;
      else if (peak_m[b] > 0) peak_m[b] = peak_m[b] - 1;
`endif
      for (int col = 0; col < BWP; col++) begin
        for (int row = 0; row < SH; row++) begin
          logic [2:0] pc;
          logic [XW-1:0] px;
          logic [YW-1:0] py;
          pc = (row >= SH - h) ? c : 3'b000;
`ifdef PEAK_HOLD_EN
          if (peak_m[b] > 0 && row == SH - peak_m[b]) pc = 3'b111;
`endif
          px = XW'(b * BWP + col);
          py = YW'(row);
          exp_q.push_back({px, py, pc});
        end
      end
    end
  endtask

  task automatic drive_start(input logic [NB*AW-1:0] a, input logic [2:0] c);
    tif.start      = 1'b1;
    tif.amps       = a;
    tif.bar_colour = c;
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    push_frame(tif.amps, tif.bar_colour);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(tag, {29'd0, tif.plot, tif.busy, tif.done}, 32'd0);
    end
  endtask

  // Follows one frame from cycle 1 (the cycle after acceptance) to done.
  task automatic run_frame(input int disturb_at, input int reset_at, input bit keep_start);
    int cyc;
    int plots;
    bit fin;
    logic [XW+YW+2:0] e;
    cyc   = 1;
    plots = 0;
    fin   = 1'b0;
    if (!keep_start) tif.start = 1'b0;
    check("busy_cycle1", 32'(tif.busy), 32'd1);
    check("plot_cycle1", 32'(tif.plot), 32'd0);
    while (!fin && cyc < 20000) begin
      if (tif.plot) begin
        plots++;
        if (exp_q.size() == 0) check("extra_plot", 32'(cyc), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("pixel", 32'({tif.x, tif.y, tif.colour}), 32'(e));
        end
      end
      if (tif.done) begin
        check("done_cycle", 32'(cyc), 32'(DONE_CYC));
        check("plot_count", 32'(plots), 32'(NB * BWP * SH));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_plot_low", 32'(tif.plot), 32'd0);
        check("busy_at_done", 32'(tif.busy), 32'd1);
        fin = 1'b1;
      end
      if (disturb_at > 0 && cyc == disturb_at) begin
        tif.start      = 1'b1;
        tif.amps       = {$urandom, $urandom};
        tif.bar_colour = 3'b111;
      end
      if (disturb_at > 0 && cyc == disturb_at + 7) tif.start = 1'b0;
      if (reset_at > 0 && cyc == reset_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_plot", 32'(tif.plot), 32'd0);
        check("reset_busy", 32'(tif.busy), 32'd0);
        check("reset_done", 32'(tif.done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        for (int b = 0; b < NB; b++) peak_m[b] = 0;
        return;
      end
      if (!fin) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!fin) check("frame_timeout", 32'(cyc), 32'(DONE_CYC));
  endtask

  initial begin
    logic [NB*AW-1:0] a;
    errors = 0;
    checks = 0;
    for (int b = 0; b < NB; b++) peak_m[b] = 0;
    reset          = 1'b1;
    tif.start      = 1'b0;
    tif.amps       = '0;
    tif.bar_colour = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(tif.x), 32'd0);
    check("rst_y", 32'(tif.y), 32'd0);
    check("rst_colour", 32'(tif.colour), 32'd0);
    check("rst_plot", 32'(tif.plot), 32'd0);
    check("rst_busy", 32'(tif.busy), 32'd0);
    check("rst_done", 32'(tif.done), 32'd0);
    reset = 1'b0;
    idle_cycles("idle_after_reset", 2);

    // Frame 1: all bands silent.
    drive_start('0, 3'b010);
    accept();
    run_frame(0, 0, 1'b0);
    $display("frame all_zero done errors=%0d checks=%0d", errors, checks);
    idle_cycles("post_frame1", 3);

    // Frame 2: band 0 full scale, band 3 half scale, with start/amps churn mid-frame.
    a = '0;
    a[0*AW +: AW] = 8'd255;
    a[3*AW +: AW] = 8'd128;
    drive_start(a, 3'b100);
    accept();
    run_frame(4000, 0, 1'b0);
    $display("frame band0_band3_disturbed done errors=%0d checks=%0d", errors, checks);
    idle_cycles("post_frame2_no_restart", 4);

    // Frame 3: abandoned by a reset at cycle 5000.
    drive_start({$urandom, $urandom}, 3'b001);
    accept();
    run_frame(0, 5000, 1'b0);
    $display("frame reset_at_5000 done errors=%0d checks=%0d", errors, checks);
    idle_cycles("post_reset_idle", 3);

    // Frames 4 and 5: start held high across DONE restarts in the first IDLE cycle.
    a = '0;
    a[0*AW +: AW] = 8'd255;
    a[5*AW +: AW] = 8'd37;
    drive_start(a, 3'b110);
    accept();
    run_frame(0, 0, 1'b1);
    $display("frame after_reset done errors=%0d checks=%0d", errors, checks);
    tif.amps = {$urandom, $urandom};
    @(posedge clk);
    #1;
    check("idle_gap_busy", 32'(tif.busy), 32'd0);
    check("idle_gap_plot", 32'(tif.plot), 32'd0);
    accept();
    run_frame(0, 0, 1'b0);
    $display("frame held_start_restart done errors=%0d checks=%0d", errors, checks);
    idle_cycles("post_frame5", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
